vga_toplevel_shell: RTL and testbench

Top-level VGA shell. From the 100 MHz board clock it generates 640x480 @ 60 Hz timing with a 25 MHz pixel-enable, and drives 12-bit RGB with an 8-bar colour test pattern. It sits directly at the FPGA pins as the display subsystem root, and is the slot where the frame-buffer source will later replace the pattern generator.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_sync_gen.sv | 51 +++++
 rtl/vga_toplevel_shell.sv | 66 ++++++
 tb/tb_vga_toplevel_shell.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, colour types and bar palette
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int BAR_WIDTH = 80;

    typedef logic [11:0] rgb12;

    localparam rgb12 BAR_WHITE   = 12'hFFF;
    localparam rgb12 BAR_YELLOW  = 12'hFF0;
    localparam rgb12 BAR_CYAN    = 12'h0FF;
    localparam rgb12 BAR_GREEN   = 12'h0F0;
    localparam rgb12 BAR_MAGENTA = 12'hF0F;
    localparam rgb12 BAR_RED     = 12'hF00;
    localparam rgb12 BAR_BLUE    = 12'h00F;
    localparam rgb12 BAR_BLACK   = 12'h000;

    function automatic rgb12 bar_colour(input logic [2:0] bar);
        case (bar)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-enable divider, h/v counters and raw sync/active decode
module vga_sync_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       active,
    output logic       hs_n,
    output logic       vs_n
);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);

    logic [1:0] div;
    logic       tick;

    // 100 MHz / 4 gives the 25 MHz pixel rate
    assign tick = (div == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= 2'd0;
            h   <= 10'd0;
            v   <= 10'd0;
        end else begin
            div <= div + 2'd1;
            if (tick) begin
                if (h == H_LAST) begin
                    h <= 10'd0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    assign hs_n   = !((h >= H_SYNC_FIRST) && (h <= H_SYNC_LAST));
    assign vs_n   = !((v >= V_SYNC_FIRST) && (v <= V_SYNC_LAST));
    assign active = (h < H_VIS) && (v < V_VIS);

endmodule

// File: rtl/vga_toplevel_shell.sv
// rtl/vga_toplevel_shell.sv - VGA root: colour-bar pattern, output registers; VGA_BORDER_EN adds a white frame
module vga_toplevel_shell
    import vga_pkg::*;
(
    input  logic        FPGA_GlobalClock,
    input  logic        FPGA_GlobalReset,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    logic [9:0] h;
    logic [9:0] v;
    logic       active;
    logic       hs_n;
    logic       vs_n;
    logic [2:0] bar;
    rgb12       pixel;

    vga_sync_gen u_sync (
        .clk    (FPGA_GlobalClock),
        .reset  (FPGA_GlobalReset),
        .h      (h),
        .v      (v),
        .active (active),
        .hs_n   (hs_n),
        .vs_n   (vs_n)
    );

    // Only meaningful while active; outside the visible width it is masked
    assign bar = 3'(h / 10'(BAR_WIDTH));

`ifdef VGA_BORDER_EN
    logic border;
    assign border = (h == 10'd0) || (h == 10'(H_ACTIVE - 1)) ||
                    (v == 10'd0) || (v == 10'(V_ACTIVE - 1));

    always_comb begin
        pixel = BAR_BLACK;
        if (active) begin
            pixel = border ? BAR_WHITE : bar_colour(bar);
        end
    end
`else
    always_comb begin
        pixel = BAR_BLACK;
        if (active) begin
            pixel = bar_colour(bar);
        end
    end
`endif

    // Everything leaves through a flop so the pins see clean, aligned edges
    always_ff @(posedge FPGA_GlobalClock) begin
        if (FPGA_GlobalReset) begin
            rgb   <= 12'h000;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= pixel;
            hsync <= hs_n;
            vsync <= vs_n;
        end
    end

endmodule

// File: tb/tb_vga_toplevel_shell.sv
// tb/tb_vga_toplevel_shell.sv - self-checking bench for vga_toplevel_shell
module tb_vga_toplevel_shell;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    int checks = 0;
    int errors = 0;

    vga_toplevel_shell dut (
        .FPGA_GlobalClock (clk),
        .FPGA_GlobalReset (rst),
        .rgb              (rgb),
        .hsync            (hsync),
        .vsync            (vsync)
    );

    always #5 clk = ~clk;

`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    localparam int FRAME_PIX = 800 * 525;

    logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Expected {rgb, hsync, vsync} for the pixel whose counters are (q % 800, q / 800)
    function automatic logic [13:0] ref_out(input int q);
        int x;
        int y;
        logic [11:0] c;
        x = q % 800;
        y = q / 800;
        c = 12'h000;
        if (x < 640 && y < 480) begin
            c = bars[3'(x / 80)];
            if (BORDER && (x == 0 || x == 639 || y == 0 || y == 479)) c = 12'hFFF;
        end
        return {c, !(x >= 656 && x <= 751), !(y >= 490 && y <= 491)};
    endfunction

    task automatic finish_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
        end
    endtask

    // Reference model: pixel position follows from clocks elapsed since reset or a counter jump
    int jump_id   = 0;
    int seen_id   = 0;
    int jump_pix  = 0;
    int base_pix  = 0;
    int cyc       = 0;
    bit armed     = 1'b0;
    bit in_rst    = 1'b0;

    always @(posedge clk) begin
        int q;
        logic [13:0] exp;
        if (rst) begin
            in_rst   = 1'b1;
            armed    = 1'b1;
            base_pix = 0;
            cyc      = 0;
        end else begin
            in_rst = 1'b0;
            if (jump_id != seen_id) begin
                seen_id  = jump_id;
                base_pix = jump_pix;
                cyc      = 1;
            end else begin
                cyc++;
            end
        end
        #1;
        if (armed) begin
            q   = (base_pix + (cyc - 1) / 4) % FRAME_PIX;
            exp = in_rst ? {12'h000, 1'b1, 1'b1} : ref_out(q);
            checks++;
            if ({rgb, hsync, vsync} !== exp) begin
                errors++;
                $display("FAIL model x=%0d y=%0d got rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b",
                         q % 800, q / 800, rgb, hsync, vsync, exp[13:2], exp[1], exp[0]);
                if (errors >= 40) finish_up();
            end
        end
    end

    // Place the counters at (hx, vy) with the divider at 0, as if that pixel had just begun
    task automatic jump(input int hx, input int vy);
        @(negedge clk);
        force dut.u_sync.div = 2'd0;
        force dut.u_sync.h   = 10'(hx);
        force dut.u_sync.v   = 10'(vy);
        #1;
        release dut.u_sync.div;
        release dut.u_sync.h;
        release dut.u_sync.v;
        jump_pix = vy * 800 + hx;
        jump_id++;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_and_measure(input string tag);
        int   n;
        int   f1;
        int   r1;
        int   f2;
        logic prev;
        @(negedge clk);
        rst  = 1'b0;
        n    = 0;
        f1   = -1;
        r1   = -1;
        f2   = -1;
        prev = 1'b1;
        while (f2 < 0 && n < 7000) begin
            @(posedge clk);
            #2;
            n++;
            if (n == 1) chk({tag, "_rgb_edge1"}, int'(rgb), 'hFFF);
            if (prev && !hsync) begin
                if (f1 < 0) f1 = n;
                else        f2 = n;
            end
            if (!prev && hsync && r1 < 0) r1 = n;
            prev = hsync;
        end
        chk({tag, "_hs_first_fall"}, f1, 2625);
        chk({tag, "_hs_low_width"}, r1 - f1, 384);
        chk({tag, "_hs_period"}, f2 - f1, 3200);
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog timeout reached");
        finish_up();
    end

    initial begin
        vec_t vecs[$];
        int   n;
        int   f;
        int   r;
        logic prev;

        vecs.push_back('{0,   10, 12'hFFF});
        vecs.push_back('{80,  10, 12'hFF0});
        vecs.push_back('{160, 10, 12'h0FF});
        vecs.push_back('{240, 10, 12'h0F0});
        vecs.push_back('{320, 10, 12'hF0F});
        vecs.push_back('{400, 10, 12'hF00});
        vecs.push_back('{480, 10, 12'h00F});
        vecs.push_back('{560, 10, 12'h000});
        vecs.push_back('{79,  10, 12'hFFF});
        vecs.push_back('{399, 10, 12'hF0F});
        vecs.push_back('{640, 10, 12'h000});
        vecs.push_back('{700, 10, 12'h000});
        vecs.push_back('{799, 10, 12'h000});
        vecs.push_back('{0,   5,  12'hFFF});
        vecs.push_back('{639, 5,  BORDER ? 12'hFFF : 12'h000});
        vecs.push_back('{639, 100, BORDER ? 12'hFFF : 12'h000});
        vecs.push_back('{400, 479, BORDER ? 12'hFFF : 12'hF00});
        vecs.push_back('{320, 0,  BORDER ? 12'hFFF : 12'hF0F});
        vecs.push_back('{100, 480, 12'h000});
        vecs.push_back('{320, 524, 12'h000});

        // Values while reset is held
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("rst_hsync", int'(hsync), 1);
            chk("rst_vsync", int'(vsync), 1);
            chk("rst_rgb", int'(rgb), 0);
        end
        release_and_measure("power_up");

        foreach (vecs[i]) begin
            jump(vecs[i].x, vecs[i].y);
            @(posedge clk);
            #2;
            chk($sformatf("pixel_%0d_%0d", vecs[i].x, vecs[i].y), int'(rgb), int'(vecs[i].exp));
        end

        // Vertical sync: starts at line 490 pixel 0, lasts two full lines
        jump(790, 489);
        n = 0; f = -1; r = -1; prev = 1'b1;
        while (r < 0 && n < 8000) begin
            @(posedge clk);
            #2;
            n++;
            if (prev && !vsync && f < 0) f = n;
            if (!prev && vsync && f >= 0) r = n;
            prev = vsync;
        end
        chk("vs_fall_edge", f, 41);
        chk("vs_low_width", r - f, 6400);

        // Frame wrap from (799,524) back to (0,0)
        jump(795, 524);
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #2;
            if (k == 20) chk("wrap_last_pixel", int'(rgb), 0);
            if (k == 21) chk("wrap_first_pixel", int'(rgb), 'hFFF);
        end

        // One-clock reset mid-line restarts the frame exactly like power-up
        jump(300, 200);
        run(100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("midrst_rgb", int'(rgb), 0);
        chk("midrst_hsync", int'(hsync), 1);
        chk("midrst_vsync", int'(vsync), 1);
        release_and_measure("mid_reset");

        // Random jumps and reset pulses, checked continuously by the model
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else begin
                jump(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            end
            run(int'($urandom_range(20, 800)));
        end

        run(4);
        finish_up();
    end

endmodule
